// File: rtl/ram_bank.sv
// Single-port memory bank with byte enables, 1-cycle registered read, out-of-range detection
// and a sequential clear engine. Optional per-byte parity when RAM_PARITY_EN is defined.
module ram_bank #(
    parameter int unsigned     WIDTH       = 32,
    parameter int unsigned     ADDR_WIDTH  = 10,
    parameter int unsigned     DEPTH       = 1024,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [WIDTH/8-1:0]      req_be,
    input  logic [WIDTH-1:0]        req_wdata,
    output logic                    rsp_valid,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    input  logic                    par_inject,
    output logic                    rsp_perr
);
    localparam int unsigned NB  = WIDTH / 8;
    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    localparam logic [AW1-1:0]        DEPTH_W = AW1'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_W  = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clr_ptr;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic in_range;
    logic accept;
    logic wr_en;
    logic rd_en;

    // Compare one bit wider so DEPTH == 2^ADDR_WIDTH is representable
    assign in_range  = {1'b0, req_addr} < DEPTH_W;
    assign req_ready = (state == S_IDLE) && !clear;
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_write && in_range;
    assign rd_en     = accept && !req_write;

`ifdef RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] wpar;

    function automatic logic [NB-1:0] lane_par(input logic [WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < int'(NB); i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    assign wpar = lane_par(req_wdata);
`else
    logic unused_par_inject;
    assign unused_par_inject = par_inject;
`endif

    // Array and parity storage: no reset, the clear engine initialises them
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            mem[clr_ptr] <= CLEAR_VALUE;
`ifdef RAM_PARITY_EN
            par[clr_ptr] <= lane_par(CLEAR_VALUE);
`endif
        end else if (wr_en) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef RAM_PARITY_EN
                    par[req_addr][i] <= wpar[i] ^ par_inject;
`endif
                end
            end
        end
    end

    // Control FSM and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_CLEAR;
            clr_ptr   <= '0;
            busy      <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            rsp_perr  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_perr  <= 1'b0;
            case (state)
                S_CLEAR: begin
                    if (clr_ptr == LAST_W) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        clr_ptr <= '0;
                    end else begin
                        clr_ptr <= clr_ptr + ADDR_WIDTH'(1);
                    end
                end
                S_IDLE: begin
                    if (clear) begin
                        state   <= S_CLEAR;
                        busy    <= 1'b1;
                        clr_ptr <= '0;
                    end else if (accept) begin
                        rsp_err <= !in_range;
                        if (rd_en) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= in_range ? mem[req_addr] : '0;
`ifdef RAM_PARITY_EN
                            rsp_perr  <= in_range && (|(par[req_addr] ^ lane_par(mem[req_addr])));
`endif
                        end
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench for ram_bank: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_ram_bank;
    localparam int unsigned W   = 32;
    localparam int unsigned AW  = 4;
    localparam int unsigned DEP = 12;
    localparam logic [W-1:0] CLR = 32'h0;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [3:0]    req_be = '0;
    logic [W-1:0]  req_wdata = '0;
    logic          rsp_valid;
    logic [W-1:0]  rsp_rdata;
    logic          rsp_err;
    logic          busy;
    logic          par_inject = 1'b0;
    logic          rsp_perr;

    ram_bank #(.WIDTH(W), .ADDR_WIDTH(AW), .DEPTH(DEP), .CLEAR_VALUE(CLR)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .par_inject(par_inject), .rsp_perr(rsp_perr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        v;
        logic        e;
        logic        p;
        logic [W-1:0] d;
    } exp_t;

    exp_t         sb[$];
    logic [W-1:0] model [DEP];
    logic [3:0]   bad   [DEP];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every response the DUT presents must match the oldest expectation
    always @(negedge clk) begin
        if (reset && (rsp_valid || rsp_err)) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {30'b0, rsp_valid, rsp_err}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
                chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, e.v});
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.e});
                if (e.v) begin
                    chk("rsp_rdata", rsp_rdata, e.d);
                    chk("rsp_perr", {31'b0, rsp_perr}, {31'b0, e.p});
                end
            end
        end
    end

    function automatic logic exp_perr(input logic [3:0] b);
`ifdef RAM_PARITY_EN
        return |b;
`else
        return 1'b0 & b[0];
`endif
    endfunction

    // Issue one request (called at posedge+1), update the model and push the expected response
    task automatic issue(input logic wr, input int a, input logic [3:0] be,
                         input logic [W-1:0] wd, input logic inj);
        exp_t e;
        req_valid = 1'b1; req_write = wr; req_addr = AW'(a);
        req_be = be; req_wdata = wd; par_inject = inj;
        @(negedge clk);
        chk("req_ready", {31'b0, req_ready}, 32'h1);
        e.cyc = cyc + 1; e.v = !wr; e.e = (a >= int'(DEP)); e.p = 1'b0; e.d = '0;
        if (a < int'(DEP)) begin
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        model[a][8*i +: 8] = wd[8*i +: 8];
                        bad[a][i] = inj;
                    end
                end
            end else begin
                e.d = model[a];
                e.p = exp_perr(bad[a]);
            end
        end
        if (e.v || e.e) sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; par_inject = 1'b0;
    endtask

    // Count busy cycles of a sweep (starting at posedge+1) and reload the model
    task automatic count_busy();
        int n = 0;
        bit done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                if (req_ready) chk("ready_while_busy", 32'h1, 32'h0);
            end else begin
                done = 1;
            end
        end
        chk("sweep_cycles", 32'(n), 32'(DEP));
        for (int i = 0; i < int'(DEP); i++) begin model[i] = CLR; bad[i] = 4'h0; end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h1);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'h0);
        chk({tag, "_valid"}, {31'b0, rsp_valid}, 32'h0);
        chk({tag, "_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_err"}, {31'b0, rsp_err}, 32'h0);
        chk({tag, "_perr"}, {31'b0, rsp_perr}, 32'h0);
    endtask

    task automatic read_all();
        for (int a = 0; a < int'(DEP); a++) issue(1'b0, a, 4'h0, 32'h0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset held for 3 cycles
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("por");
        reset = 1'b1;
        count_busy();
        read_all();

        // Byte-lane merge
        issue(1'b1, 5, 4'hF, 32'hDEADBEEF, 1'b0);
        issue(1'b1, 5, 4'b0001, 32'h000000AA, 1'b0);
        issue(1'b0, 5, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 6, 4'h0, 32'hFFFFFFFF, 1'b0);
        issue(1'b0, 6, 4'h0, 32'h0, 1'b0);

        // Out-of-range write and read, array untouched
        issue(1'b1, 13, 4'hF, 32'h55AA55AA, 1'b0);
        issue(1'b0, 13, 4'h0, 32'h0, 1'b0);
        issue(1'b0, 12, 4'h0, 32'h0, 1'b0);
        read_all();

        // Parity inject on one lane, then a clean rewrite
        issue(1'b1, 2, 4'b0100, 32'h12345678, 1'b1);
        issue(1'b0, 2, 4'h0, 32'h0, 1'b0);
        issue(1'b1, 2, 4'b0100, 32'h12345678, 1'b0);
        issue(1'b0, 2, 4'h0, 32'h0, 1'b0);

        // Random traffic with occasional idle gaps
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
            issue(1'($urandom), int'($urandom_range(0, 15)), 4'($urandom), $urandom,
                  ($urandom_range(0, 7) == 0));
        end
        @(posedge clk); #1;

        // Clear has priority over a simultaneous request
        clear = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 4'd3;
        @(negedge clk);
        chk("ready_with_clear", {31'b0, req_ready}, 32'h0);
        @(posedge clk); #1;
        clear = 1'b0; req_valid = 1'b0;
        count_busy();
        read_all();

        // Reset mid-sweep at clr_ptr==7
        issue(1'b1, 9, 4'hF, 32'hCAFEF00D, 1'b0);
        issue(1'b0, 9, 4'h0, 32'h0, 1'b0);
        @(posedge clk); #1;
        chk("rdata_held", rsp_rdata, 32'hCAFEF00D);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset = 1'b0;
        #1 check_reset_outputs("mid");
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        count_busy();
        read_all();

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
